btn_conditioner: RTL and testbench

//   Front-end conditioner for the board push-buttons (BTNL/BTNC/BTNR/BTNU/BTND).

---
 rtl/btn_conditioner.sv | 145 ++++++++++++++
 tb/tb_btn_conditioner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Per-channel 2-FF synchroniser + debounce FSM giving a clean level and 1-cycle press/release strobes.
// Latency: DEBOUNCE_CYCLES+3 clk from a stable raw edge to the output change.
// No backpressure: strobes are fire-and-forget; optional auto-repeat built when BTN_REPEAT_EN is defined.
module btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef BTN_REPEAT_EN
    localparam int            RW         = $clog2(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_ONE    = RW'(1);
    // Reloading here makes later strobes land REPEAT_PERIOD apart.
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

    // Configurations the repeat reload cannot express leave this marker block in the hierarchy.
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY || DEBOUNCE_CYCLES < 2) begin : g_cfg_unsupported
    end

    typedef enum logic [1:0] {IDLE, PRESS_WT, HELD, REL_WT} state_t;

    logic [N_BTN-1:0] sync_meta;
    logic [N_BTN-1:0] sync_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_s    <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync_s    <= sync_meta;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_t        state, state_nxt;
        logic [CW-1:0] cnt, cnt_nxt;
        logic          level_q, level_nxt;
        logic          press_q, press_nxt;
        logic          release_q, release_nxt;
        logic          rep_fire;

`ifdef BTN_REPEAT_EN
        logic [RW-1:0] rep_cnt, rep_nxt;

        always_comb begin
            rep_nxt  = '0;
            rep_fire = 1'b0;
            if (state == HELD && sync_s[i]) begin
                if (rep_cnt == REP_LAST) begin
                    rep_fire = 1'b1;
                    rep_nxt  = REP_RELOAD;
                end else begin
                    rep_nxt  = rep_cnt + REP_ONE;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) rep_cnt <= '0;
            else       rep_cnt <= rep_nxt;
        end
`else
        assign rep_fire = 1'b0;
`endif

        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            level_nxt   = level_q;
            press_nxt   = rep_fire;
            release_nxt = 1'b0;
            case (state)
                IDLE: begin
                    if (sync_s[i]) begin
                        state_nxt = PRESS_WT;
                        cnt_nxt   = '0;
                    end
                end
                PRESS_WT: begin
                    if (!sync_s[i]) begin
                        state_nxt = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = HELD;
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt   = cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!sync_s[i]) begin
                        state_nxt = REL_WT;
                        cnt_nxt   = '0;
                    end
                end
                REL_WT: begin
                    if (sync_s[i]) begin
                        state_nxt   = HELD;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt   = IDLE;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_nxt     = cnt + CNT_ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state     <= IDLE;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: vector table for press/release/glitch/multi-channel,
// hand sequences for reset-in-flight and auto-repeat.
module tb_btn_conditioner;
    localparam int N_BTN = 5;
    localparam int DEB   = 4;
    localparam int RDLY  = 10;
    localparam int RPER  = 3;
`ifdef BTN_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N_BTN-1:0] btn_raw = '0;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    int checks = 0;
    int errors = 0;

    btn_conditioner #(
        .N_BTN(N_BTN), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    // Each row: drive raw, then for n edges expect {level, press, release}.
    typedef struct {
        logic [4:0] raw;
        int         n;
        logic [4:0] lvl;
        logic [4:0] prs;
        logic [4:0] rel;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [4:0] raw, input int n,
                                input logic [4:0] lvl, input logic [4:0] prs, input logic [4:0] rel);
        vec_t v;
        v.raw = raw; v.n = n; v.lvl = lvl; v.prs = prs; v.rel = rel;
        tbl.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [4:0] lvl, input logic [4:0] prs,
                       input logic [4:0] rel);
        checks++;
        if ({btn_level, btn_press, btn_release} !== {lvl, prs, rel}) begin
            errors++;
            $display("FAIL %s: got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
                     name, btn_level, btn_press, btn_release, lvl, prs, rel);
        end
    endtask

    initial begin
        // Press ch0 at edge 0: level+strobe after edge 7.
        add(5'b00001, 6, 5'b00000, 5'b00000, 5'b00000);
        add(5'b00001, 1, 5'b00001, 5'b00001, 5'b00000);
        add(5'b00001, 2, 5'b00001, 5'b00000, 5'b00000);
        // Two-cycle low glitch while held: no release.
        add(5'b00000, 2, 5'b00001, 5'b00000, 5'b00000);
        add(5'b00001, 8, 5'b00001, 5'b00000, 5'b00000);
        // Real release.
        add(5'b00000, 6, 5'b00001, 5'b00000, 5'b00000);
        add(5'b00000, 1, 5'b00000, 5'b00000, 5'b00001);
        add(5'b00000, 3, 5'b00000, 5'b00000, 5'b00000);
        // Bouncy press shorter than the debounce window.
        add(5'b00001, 2, 5'b00000, 5'b00000, 5'b00000);
        add(5'b00000, 1, 5'b00000, 5'b00000, 5'b00000);
        add(5'b00001, 2, 5'b00000, 5'b00000, 5'b00000);
        add(5'b00000, 8, 5'b00000, 5'b00000, 5'b00000);
        // Channels 0 and 4 together, then ch4 released first.
        add(5'b10001, 6, 5'b00000, 5'b00000, 5'b00000);
        add(5'b10001, 1, 5'b10001, 5'b10001, 5'b00000);
        add(5'b00001, 4, 5'b10001, 5'b00000, 5'b00000);
        add(5'b00000, 2, 5'b10001, 5'b00000, 5'b00000);
        add(5'b00000, 1, 5'b00001, 5'b00000, 5'b10000);
        add(5'b00000, 3, 5'b00001, 5'b00000, 5'b00000);
        add(5'b00000, 1, 5'b00000, 5'b00000, 5'b00001);
        add(5'b00000, 2, 5'b00000, 5'b00000, 5'b00000);

        repeat (3) step();
        chk("reset_state", 5'b0, 5'b0, 5'b0);
        reset = 1'b0;
        step();
        chk("post_reset_idle", 5'b0, 5'b0, 5'b0);

        foreach (tbl[r]) begin
            btn_raw = tbl[r].raw;
            for (int k = 0; k < tbl[r].n; k++) begin
                step();
                chk($sformatf("vec%0d_cyc%0d", r, k), tbl[r].lvl, tbl[r].prs, tbl[r].rel);
            end
        end

        // Reset while ch2 is in PRESS_WT, raw kept high.
        btn_raw = 5'b00100;
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("rst_press_wt_now", 5'b0, 5'b0, 5'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_press_wt_hold", 5'b0, 5'b0, 5'b0);
        end
        reset = 1'b0;
        for (int k = 1; k <= DEB + 2; k++) begin
            step();
            chk($sformatf("rst1_redeb_%0d", k), 5'b0, 5'b0, 5'b0);
        end
        step();
        chk("rst1_fresh_press", 5'b00100, 5'b00100, 5'b0);
        step();
        chk("rst1_held", 5'b00100, 5'b0, 5'b0);

        // Reset while ch2 is HELD: level drops at once, no strobe afterwards.
        reset = 1'b1;
        #1;
        chk("rst_held_now", 5'b0, 5'b0, 5'b0);
        step();
        chk("rst_held_hold", 5'b0, 5'b0, 5'b0);
        reset = 1'b0;
        for (int k = 1; k <= DEB + 2; k++) begin
            step();
            chk($sformatf("rst2_redeb_%0d", k), 5'b0, 5'b0, 5'b0);
        end
        step();
        chk("rst2_fresh_press", 5'b00100, 5'b00100, 5'b0);
        btn_raw = 5'b0;
        repeat (8) step();
        chk("rst2_released_idle", 5'b0, 5'b0, 5'b0);

        // Long hold on ch1: repeat strobes only when the feature is built.
        btn_raw = 5'b00010;
        repeat (DEB + 3) step();
        chk("hold_press", 5'b00010, 5'b00010, 5'b0);
        for (int k = 1; k <= 30; k++) begin
            logic rep;
            rep = REP_EN && (k >= RDLY) && ((k - RDLY) % RPER == 0);
            step();
            chk($sformatf("hold_plus%0d", k), 5'b00010, {3'b000, rep, 1'b0}, 5'b0);
        end
        btn_raw = 5'b0;
        repeat (DEB + 2) step();
        step();
        chk("hold_release", 5'b0, 5'b0, 5'b00010);
        step();
        chk("hold_idle", 5'b0, 5'b0, 5'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
